// File: rtl/calc_pkg.sv
// Shared constants, opcodes and FSM states
// for the ASCII calculator command parser.
package calc_pkg;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_NINE  = 8'h39;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_STAR  = 8'h2A;
  localparam logic [7:0] ASC_AMP   = 8'h26;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_SPACE = 8'h20;

  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_SUB = 2'b01;
  localparam logic [1:0] OPC_MUL = 2'b10;
  localparam logic [1:0] OPC_AND = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    A_ACC   = 2'd1,
    OP_WAIT = 2'd2,
    B_ACC   = 2'd3
  } state_t;

  function automatic logic is_digit(
    input logic [7:0] b
  );
    return (b >= ASC_ZERO) && (b <= ASC_NINE);
  endfunction

  function automatic logic is_oper(
    input logic [7:0] b
  );
    return (b == ASC_PLUS) || (b == ASC_MINUS)
        || (b == ASC_STAR) || (b == ASC_AMP);
  endfunction

  function automatic logic [1:0] op_enc(
    input logic [7:0] b
  );
    logic [1:0] r;
    r = OPC_ADD;
    unique case (1'b1)
      (b == ASC_MINUS): r = OPC_SUB;
      (b == ASC_STAR):  r = OPC_MUL;
      (b == ASC_AMP):   r = OPC_AND;
      default:          r = OPC_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dec_acc.sv
// Decimal accumulate step: acc*10 + digit,
// with overflow when the result exceeds DATA_W bits.
module dec_acc #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  logic [DATA_W+3:0] acc_x;
  logic [DATA_W+3:0] wide;

  // Widened so (2^W-1)*10+9 never wraps.
  always_comb begin
    acc_x = {4'b0000, acc};
    wide  = (acc_x << 3) + (acc_x << 1)
          + {{DATA_W{1'b0}}, digit};
    sum   = wide[DATA_W-1:0];
    ovf   = |wide[DATA_W+3:DATA_W];
  end

endmodule

// File: rtl/calc_cmd_parser.sv
// Parses "digits op digits =" from a byte stream
// into operands and an opcode, flagging bad input.
module calc_cmd_parser
  import calc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        opcode,
  output logic              cmd_valid,
  output logic              err
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] a_lat;
  logic [1:0]        opc_lat;

  logic [DATA_W-1:0] acc_in;
  logic [DATA_W-1:0] acc_nx;
  logic              acc_ovf;
  logic              b_dig;
  logic              b_op;
  logic              b_eq;
  logic              b_sp;

  // First digit of an operand starts from zero.
  always_comb begin
    acc_in = '0;
    if (state == A_ACC || state == B_ACC)
      acc_in = acc;
    b_dig = is_digit(rx_data);
    b_op  = is_oper(rx_data);
    b_eq  = (rx_data == ASC_EQ);
    b_sp  = (rx_data == ASC_SPACE);
  end

  dec_acc #(
    .DATA_W(DATA_W)
  ) u_acc (
    .acc  (acc_in),
    .digit(rx_data[3:0]),
    .sum  (acc_nx),
    .ovf  (acc_ovf)
  );

  // Command FSM with registered outputs and pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      a_lat     <= '0;
      opc_lat   <= OPC_ADD;
      op_a      <= '0;
      op_b      <= '0;
      opcode    <= OPC_ADD;
      cmd_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      if (rx_rdy && !b_sp) begin
        unique case (state)
          IDLE, OP_WAIT: begin
            if (b_dig && !acc_ovf) begin
              acc   <= acc_nx;
              state <= (state == IDLE) ? A_ACC : B_ACC;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          A_ACC: begin
            if (b_dig && !acc_ovf) begin
              acc <= acc_nx;
            end else if (b_op) begin
              a_lat   <= acc;
              opc_lat <= op_enc(rx_data);
              state   <= OP_WAIT;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          B_ACC: begin
            if (b_dig && !acc_ovf) begin
              acc <= acc_nx;
            end else if (b_eq) begin
              op_a      <= a_lat;
              op_b      <= acc;
              opcode    <= opc_lat;
              cmd_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_cmd_parser.sv
// Directed bench for calc_cmd_parser:
// byte-by-byte stimulus with pulse and operand checks.
module tb_calc_cmd_parser;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] opcode;
  logic       cmd_valid;
  logic       err;

  int checks;
  int failures;

  calc_cmd_parser #(
    .DATA_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .op_a     (op_a),
    .op_b     (op_b),
    .opcode   (opcode),
    .cmd_valid(cmd_valid),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic       r,
    input logic       v,
    input logic [7:0] d
  );
    @(negedge clk);
    rst     = r;
    rx_rdy  = v;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic put(
    input logic [7:0] d,
    input logic       ev,
    input logic       ee
  );
    step(1'b1, 1'b1, d);
    chk($sformatf("cv_%s", d), {31'd0, cmd_valid},
        {31'd0, ev});
    chk($sformatf("err_%s", d), {31'd0, err},
        {31'd0, ee});
  endtask

  task automatic ops(
    input string      tag,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] o
  );
    chk({tag, "_a"}, {24'd0, op_a}, {24'd0, a});
    chk({tag, "_b"}, {24'd0, op_b}, {24'd0, b});
    chk({tag, "_op"}, {30'd0, opcode}, {30'd0, o});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    rx_rdy   = 1'b0;
    rx_data  = 8'h00;

    // reset with rx_rdy active: byte ignored
    step(1'b0, 1'b1, "5");
    step(1'b0, 1'b1, "5");
    chk("rst_cv", {31'd0, cmd_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    ops("rst", 8'd0, 8'd0, 2'b00);
    step(1'b1, 1'b0, 8'h00);

    // "12+34="
    put("1", 0, 0); put("2", 0, 0); put("+", 0, 0);
    put("3", 0, 0); put("4", 0, 0); put("=", 1, 0);
    ops("add", 8'd12, 8'd34, 2'b00);
    step(1'b1, 1'b0, 8'h00);
    chk("add_pulse_end", {31'd0, cmd_valid}, 32'd0);
    ops("add_hold", 8'd12, 8'd34, 2'b00);

    // " 7 - 3 = "
    put(" ", 0, 0); put("7", 0, 0); put(" ", 0, 0);
    put("-", 0, 0); put(" ", 0, 0); put("3", 0, 0);
    put(" ", 0, 0); put("=", 1, 0);
    ops("sub", 8'd7, 8'd3, 2'b01);
    put(" ", 0, 0);

    // "255*2=" boundary value
    put("2", 0, 0); put("5", 0, 0); put("5", 0, 0);
    put("*", 0, 0); put("2", 0, 0); put("=", 1, 0);
    ops("mul", 8'd255, 8'd2, 2'b10);

    // "256&1=" overflow on A
    put("2", 0, 0); put("5", 0, 0); put("6", 0, 1);
    put("&", 0, 1); put("1", 0, 0); put("=", 0, 1);
    ops("ovf_hold", 8'd255, 8'd2, 2'b10);

    // "12=" and "+5="
    put("1", 0, 0); put("2", 0, 0); put("=", 0, 1);
    put("+", 0, 1); put("5", 0, 0); put("=", 0, 1);
    ops("bad_hold", 8'd255, 8'd2, 2'b10);

    // overflow on B: "1+256="
    put("1", 0, 0); put("+", 0, 0); put("2", 0, 0);
    put("5", 0, 0); put("6", 0, 1); put("=", 0, 1);

    // gaps in rx_rdy hold the state: "3 _ 4-10="
    put("3", 0, 0);
    step(1'b1, 1'b0, "9");
    chk("gap_cv", {31'd0, cmd_valid}, 32'd0);
    put("4", 0, 0); put("-", 0, 0);
    step(1'b1, 1'b0, "=");
    put("1", 0, 0); put("0", 0, 0); put("=", 1, 0);
    ops("gap", 8'd34, 8'd10, 2'b01);

    // reset mid-command: "12+" rst "5&6="
    put("1", 0, 0); put("2", 0, 0); put("+", 0, 0);
    step(1'b0, 1'b0, 8'h00);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    ops("mid_rst", 8'd0, 8'd0, 2'b00);
    put("5", 0, 0); put("&", 0, 0); put("6", 0, 0);
    put("=", 1, 0);
    ops("and", 8'd5, 8'd6, 2'b11);

    // back-to-back "9+9=" "1+1="
    put("9", 0, 0); put("+", 0, 0); put("9", 0, 0);
    put("=", 1, 0);
    ops("b2b_1", 8'd9, 8'd9, 2'b00);
    put("1", 0, 0); put("+", 0, 0); put("1", 0, 0);
    put("=", 1, 0);
    ops("b2b_2", 8'd1, 8'd1, 2'b00);

    // byte on the error-pulse cycle starts fresh
    put("=", 0, 1); put("4", 0, 0); put("*", 0, 0);
    put("8", 0, 0); put("=", 1, 0);
    ops("after_err", 8'd4, 8'd8, 2'b10);

    step(1'b1, 1'b0, 8'h00);
    chk("final_cv", {31'd0, cmd_valid}, 32'd0);
    chk("final_err", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
